id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 49 ++++
 rtl/id_ex_reg_load_use_detect.sv | 28 ++
 rtl/id_ex_reg.sv | 99 +++++++++
 tb/tb_id_ex_reg.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared types and encodings for the ID/EX pipeline register and its hazard detector.
// ctrl_t carries the decoder's control outputs into the execute stage.
package id_ex_reg_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_DEFAULT = 3'd0,
        IMM_I       = 3'd1,
        IMM_S       = 3'd2,
        IMM_B       = 3'd3,
        IMM_U       = 3'd4,
        IMM_J       = 3'd5
    } imm_cntrl_e;

    typedef enum logic [1:0] {
        REG_SRC_ALU = 2'd0,
        REG_SRC_MEM = 2'd1,
        REG_SRC_PC  = 2'd2
    } reg_src_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       branch;
        logic       jump;
        logic [2:0] aluCntrl;
        logic [2:0] immCntrl;
        logic [1:0] aluSrcA;
        logic       aluSrcB;
        logic       inv;
        logic       useF7;
        logic [1:0] regSrc;
        logic       pcTargetSrc;
        logic       loadStore;
    } ctrl_t;

    // rs2 is a real operand for R-type and branches (register B input) and for stores (write data).
    function automatic logic uses_rs2(input logic alu_src_b, input logic mem_write);
        return !alu_src_b || mem_write;
    endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction waiting in decode.
module load_use_detect
    import id_ex_reg_pkg::*;
(
    input  logic       idValid,
    input  logic       idAluSrcB,
    input  logic       idMemWrite,
    input  logic [4:0] idRs1Addr,
    input  logic [4:0] idRs2Addr,
    input  logic       exValid,
    input  logic       exLoadStore,
    input  logic       exMemWrite,
    input  logic [4:0] exRdAddr,
    output logic       loadUse
);

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;

    // A load writing x0 produces nothing to forward, so it never creates a hazard.
    assign ex_is_load = exValid && exLoadStore && !exMemWrite && (exRdAddr != 5'd0);
    assign rs1_match  = (exRdAddr == idRs1Addr);
    assign rs2_match  = uses_rs2(idAluSrcB, idMemWrite) && (exRdAddr == idRs2Addr);
    assign loadUse    = idValid && ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: single-entry elastic stage with flush, load-use
// bubble insertion and a saturating bubble counter.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN  = id_ex_reg_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             idValid,
    output logic             idReady,
    input  ctrl_t            idCtrl,
    input  logic [XLEN-1:0]  idPc,
    input  logic [XLEN-1:0]  idPcPlus4,
    input  logic [XLEN-1:0]  idRs1Data,
    input  logic [XLEN-1:0]  idRs2Data,
    input  logic [XLEN-1:0]  idImm,
    input  logic [4:0]       idRs1Addr,
    input  logic [4:0]       idRs2Addr,
    input  logic [4:0]       idRdAddr,
    input  logic             flush,
    output logic             exValid,
    input  logic             exReady,
    output ctrl_t            exCtrl,
    output logic [XLEN-1:0]  exPc,
    output logic [XLEN-1:0]  exPcPlus4,
    output logic [XLEN-1:0]  exRs1Data,
    output logic [XLEN-1:0]  exRs2Data,
    output logic [XLEN-1:0]  exImm,
    output logic [4:0]       exRs1Addr,
    output logic [4:0]       exRs2Addr,
    output logic [4:0]       exRdAddr,
    output logic             loadUseStall,
    output logic [CNT_W-1:0] bubbleCnt
);

    logic advance;
    logic load_use;

    load_use_detect u_load_use_detect (
        .idValid     (idValid),
        .idAluSrcB   (idCtrl.aluSrcB),
        .idMemWrite  (idCtrl.memWrite),
        .idRs1Addr   (idRs1Addr),
        .idRs2Addr   (idRs2Addr),
        .exValid     (exValid),
        .exLoadStore (exCtrl.loadStore),
        .exMemWrite  (exCtrl.memWrite),
        .exRdAddr    (exRdAddr),
        .loadUse     (load_use)
    );

    assign advance      = !exValid || exReady;
    assign loadUseStall = load_use && !flush;
    assign idReady      = advance && !load_use && !flush;

    // Priority: reset, flush, bubble, capture, drain to empty, hold.
    // Data fields are left untouched whenever the entry goes empty; only ctrl is scrubbed.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            exValid   <= 1'b0;
            exCtrl    <= '0;
            exPc      <= '0;
            exPcPlus4 <= '0;
            exRs1Data <= '0;
            exRs2Data <= '0;
            exImm     <= '0;
            exRs1Addr <= '0;
            exRs2Addr <= '0;
            exRdAddr  <= '0;
            bubbleCnt <= '0;
        end else if (flush) begin
            exValid <= 1'b0;
            exCtrl  <= '0;
        end else if (load_use && advance) begin
            exValid <= 1'b0;
            exCtrl  <= '0;
            if (bubbleCnt != '1) begin
                bubbleCnt <= bubbleCnt + CNT_W'(1);
            end
        end else if (idValid && idReady) begin
            exValid   <= 1'b1;
            exCtrl    <= idCtrl;
            exPc      <= idPc;
            exPcPlus4 <= idPcPlus4;
            exRs1Data <= idRs1Data;
            exRs2Data <= idRs2Data;
            exImm     <= idImm;
            exRs1Addr <= idRs1Addr;
            exRs2Addr <= idRs2Addr;
            exRdAddr  <= idRdAddr;
        end else if (advance) begin
            exValid <= 1'b0;
            exCtrl  <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    localparam int W     = 32;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             idValid = 1'b0;
    logic             idReady;
    ctrl_t            idCtrl = '0;
    logic [W-1:0]     idPc = '0, idPcPlus4 = '0, idRs1Data = '0, idRs2Data = '0, idImm = '0;
    logic [4:0]       idRs1Addr = '0, idRs2Addr = '0, idRdAddr = '0;
    logic             flush = 1'b0;
    logic             exValid;
    logic             exReady = 1'b1;
    ctrl_t            exCtrl;
    logic [W-1:0]     exPc, exPcPlus4, exRs1Data, exRs2Data, exImm;
    logic [4:0]       exRs1Addr, exRs2Addr, exRdAddr;
    logic             loadUseStall;
    logic [CNT_W-1:0] bubbleCnt;

    int n_checks = 0;
    int n_fails  = 0;

    id_ex_reg #(.XLEN(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstN(rstN),
        .idValid(idValid), .idReady(idReady), .idCtrl(idCtrl),
        .idPc(idPc), .idPcPlus4(idPcPlus4), .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
        .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr), .idRdAddr(idRdAddr),
        .flush(flush), .exValid(exValid), .exReady(exReady), .exCtrl(exCtrl),
        .exPc(exPc), .exPcPlus4(exPcPlus4), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data), .exImm(exImm),
        .exRs1Addr(exRs1Addr), .exRs2Addr(exRs2Addr), .exRdAddr(exRdAddr),
        .loadUseStall(loadUseStall), .bubbleCnt(bubbleCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t mk_alu(input logic use_imm);
        ctrl_t c = '0;
        c.regWrite = 1'b1;
        c.aluSrcB  = use_imm;
        c.immCntrl = use_imm ? IMM_I : IMM_DEFAULT;
        c.regSrc   = REG_SRC_ALU;
        return c;
    endfunction

    function automatic ctrl_t mk_load();
        ctrl_t c = '0;
        c.regWrite  = 1'b1;
        c.aluSrcB   = 1'b1;
        c.immCntrl  = IMM_I;
        c.regSrc    = REG_SRC_MEM;
        c.loadStore = 1'b1;
        return c;
    endfunction

    // Drive one cycle of inputs just after the falling edge; outputs settle before the caller checks.
    task automatic applyStimulus(input logic v, input ctrl_t c, input logic [W-1:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic rdy, input logic fl, input logic rst_n);
        @(negedge clk);
        idValid   = v;
        idCtrl    = c;
        idPc      = pc;
        idPcPlus4 = pc + 32'd4;
        idRs1Data = pc ^ 32'hA5A5_0000;
        idRs2Data = pc ^ 32'h5A5A_1111;
        idImm     = ~pc;
        idRs1Addr = rs1;
        idRs2Addr = rs2;
        idRdAddr  = rd;
        exReady   = rdy;
        flush     = fl;
        rstN      = rst_n;
        #3;
    endtask

    // Transaction-level model: what sits in EX and how many bubbles have been inserted.
    logic       m_known = 1'b0;
    logic       m_valid;
    ctrl_t      m_ctrl;
    logic [W-1:0] m_pc, m_pc4, m_rs1d, m_rs2d, m_imm;
    logic [4:0] m_rs1a, m_rs2a, m_rd;
    int         m_cnt;

    function automatic logic model_hazard();
        logic ex_load, needs_rs2;
        ex_load   = m_valid && m_ctrl.loadStore && !m_ctrl.memWrite && (m_rd != 5'd0);
        needs_rs2 = !idCtrl.aluSrcB || idCtrl.memWrite;
        return idValid && ex_load && (m_rd == idRs1Addr || (needs_rs2 && m_rd == idRs2Addr));
    endfunction

    always begin : compare
        logic hz, adv, take, empty_next, bubble, capture, did_reset;
        @(negedge clk);
        #2;
        hz = 1'b0; adv = 1'b0; take = 1'b0;
        if (m_known) begin
            hz   = model_hazard();
            adv  = !m_valid || exReady;
            take = adv && !hz && !flush;
            checkOutput("idReady", 64'(idReady), 64'(take));
            checkOutput("loadUseStall", 64'(loadUseStall), 64'(hz && !flush));
        end
        did_reset  = !rstN;
        bubble     = rstN && !flush && hz && adv;
        capture    = rstN && !flush && idValid && take;
        empty_next = rstN && (flush || (adv && !capture));
        @(posedge clk);
        #1;
        if (did_reset) begin
            m_known = 1'b1;
            m_valid = 1'b0; m_ctrl = '0; m_cnt = 0;
        end else if (m_known) begin
            if (bubble) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (capture) begin
                m_valid = 1'b1; m_ctrl = idCtrl;
                m_pc = idPc; m_pc4 = idPcPlus4; m_rs1d = idRs1Data; m_rs2d = idRs2Data; m_imm = idImm;
                m_rs1a = idRs1Addr; m_rs2a = idRs2Addr; m_rd = idRdAddr;
            end else if (empty_next) begin
                m_valid = 1'b0; m_ctrl = '0;
            end
        end
        if (m_known) begin
            checkOutput("exValid", 64'(exValid), 64'(m_valid));
            checkOutput("exCtrl", 64'(exCtrl), 64'(m_ctrl));
            checkOutput("bubbleCnt", 64'(bubbleCnt), 64'(m_cnt));
            if (m_valid) begin
                checkOutput("exPc", 64'(exPc), 64'(m_pc));
                checkOutput("exPcPlus4", 64'(exPcPlus4), 64'(m_pc4));
                checkOutput("exRs1Data", 64'(exRs1Data), 64'(m_rs1d));
                checkOutput("exRs2Data", 64'(exRs2Data), 64'(m_rs2d));
                checkOutput("exImm", 64'(exImm), 64'(m_imm));
                checkOutput("exAddrs", {49'd0, exRs1Addr, exRs2Addr, exRdAddr}, {49'd0, m_rs1a, m_rs2a, m_rd});
            end
        end
    end

    initial begin
        ctrl_t add, addi, ld, rc;
        logic [$bits(ctrl_t)-1:0] raw;
        add  = mk_alu(1'b0);
        addi = mk_alu(1'b1);
        ld   = mk_load();

        // Reset held two cycles with a valid instruction offered
        applyStimulus(1, add, 32'h100, 1, 2, 3, 1, 0, 0);
        applyStimulus(1, add, 32'h100, 1, 2, 3, 1, 0, 0);
        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        checkOutput("rst exValid", 64'(exValid), 64'd0);
        checkOutput("rst exCtrl", 64'(exCtrl), 64'd0);
        checkOutput("rst bubbleCnt", 64'(bubbleCnt), 64'd0);
        checkOutput("rst exPc", 64'(exPc), 64'd0);
        checkOutput("rst idReady", 64'(idReady), 64'd1);

        // Streaming three ADDs
        applyStimulus(1, add, 32'h0, 1, 2, 3, 1, 0, 1);
        checkOutput("stream idReady", 64'(idReady), 64'd1);
        applyStimulus(1, add, 32'h4, 1, 2, 3, 1, 0, 1);
        checkOutput("stream exPc0", 64'(exPc), 64'h0);
        checkOutput("stream exValid", 64'(exValid), 64'd1);
        applyStimulus(1, add, 32'h8, 1, 2, 3, 1, 0, 1);
        checkOutput("stream exPc4", 64'(exPc), 64'h4);
        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        checkOutput("stream exPc8", 64'(exPc), 64'h8);
        checkOutput("stream bubbleCnt", 64'(bubbleCnt), 64'd0);

        // Load-use: load x5 then ADD reading x5
        applyStimulus(1, ld, 32'h10, 1, 0, 5, 1, 0, 1);
        applyStimulus(1, add, 32'h20, 5, 2, 6, 1, 0, 1);
        checkOutput("lu stall", 64'(loadUseStall), 64'd1);
        checkOutput("lu idReady", 64'(idReady), 64'd0);
        checkOutput("lu exPc", 64'(exPc), 64'h10);
        applyStimulus(1, add, 32'h20, 5, 2, 6, 1, 0, 1);
        checkOutput("lu bubble exValid", 64'(exValid), 64'd0);
        checkOutput("lu bubbleCnt", 64'(bubbleCnt), 64'd1);
        checkOutput("lu release idReady", 64'(idReady), 64'd1);
        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        checkOutput("lu captured exPc", 64'(exPc), 64'h20);
        checkOutput("lu captured exRd", 64'(exRdAddr), 64'd6);

        // No false stall: rd=x0 load, and ADDI whose rs2 field matches
        applyStimulus(1, ld, 32'h30, 1, 0, 0, 1, 0, 1);
        applyStimulus(1, add, 32'h34, 0, 0, 3, 1, 0, 1);
        checkOutput("x0 stall", 64'(loadUseStall), 64'd0);
        checkOutput("x0 idReady", 64'(idReady), 64'd1);
        applyStimulus(1, ld, 32'h38, 1, 0, 5, 1, 0, 1);
        applyStimulus(1, addi, 32'h3C, 1, 5, 7, 1, 0, 1);
        checkOutput("addi stall", 64'(loadUseStall), 64'd0);
        checkOutput("addi idReady", 64'(idReady), 64'd1);

        // Backpressure for three cycles while FULL
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, add, 32'h40, 1, 2, 4, 0, 0, 1);
            checkOutput("bp exPc", 64'(exPc), 64'h3C);
            checkOutput("bp exRd", 64'(exRdAddr), 64'd7);
            checkOutput("bp idReady", 64'(idReady), 64'd0);
        end
        applyStimulus(1, add, 32'h40, 1, 2, 4, 1, 0, 1);
        checkOutput("bp release idReady", 64'(idReady), 64'd1);
        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        checkOutput("bp captured exPc", 64'(exPc), 64'h40);

        // Flush concurrent with a load-use hazard
        applyStimulus(1, ld, 32'h50, 1, 0, 5, 1, 0, 1);
        applyStimulus(1, add, 32'h54, 5, 2, 6, 1, 1, 1);
        checkOutput("flush stall", 64'(loadUseStall), 64'd0);
        checkOutput("flush idReady", 64'(idReady), 64'd0);
        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        checkOutput("flush exValid", 64'(exValid), 64'd0);
        checkOutput("flush regWrite", 64'(exCtrl.regWrite), 64'd0);
        checkOutput("flush bubbleCnt", 64'(bubbleCnt), 64'd1);

        // Reset in the middle of a hold
        applyStimulus(1, add, 32'h60, 1, 2, 3, 1, 0, 1);
        applyStimulus(1, add, 32'h64, 1, 2, 3, 0, 0, 1);
        applyStimulus(1, add, 32'h64, 1, 2, 3, 0, 0, 0);
        applyStimulus(1, add, 32'h68, 1, 2, 3, 0, 0, 1);
        checkOutput("hold rst exValid", 64'(exValid), 64'd0);
        checkOutput("hold rst idReady", 64'(idReady), 64'd1);
        checkOutput("hold rst bubbleCnt", 64'(bubbleCnt), 64'd0);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            raw = $bits(ctrl_t)'($urandom);
            rc  = raw;
            rc.loadStore = ($urandom_range(0, 2) == 0);
            applyStimulus(($urandom_range(0, 9) < 7), rc, $urandom,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 199) != 0));
        end

        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, add, 32'h0, 0, 0, 0, 1, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
